// File: rtl/control_fsm.sv
// Multicycle RV32 control unit: sequences fetch/decode/execute/writeback
// and drives datapath selects and write enables for lw, sw, R/I ALU ops,
// beq/bne and jal.
module control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       ZeroE,
    output logic [2:0] ALUctrl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       retire,
    output logic       illegal
);

    localparam int unsigned OP_W  = 7;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned SEL_W = 2;

    // Opcodes
    localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I    = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BR   = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;

    // ALU operations
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

    // Operand / result selects
    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RD1   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_RD2   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;
    localparam logic [SEL_W-1:0] RES_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU    = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL
    } state_t;

    // Per-state Moore control word held in a register alongside the state
    typedef struct packed {
        logic [ALU_W-1:0] aluctrl;
        logic [SEL_W-1:0] srca;
        logic [SEL_W-1:0] srcb;
        logic [SEL_W-1:0] resultsrc;
        logic             adrsrc;
        logic             irwrite;
        logic             regwrite;
        logic             memwrite;
        logic             retire;
    } ctrl_t;

    localparam ctrl_t CTRL_FETCH = '{
        aluctrl:   ALU_ADD,
        srca:      SRCA_PC,
        srcb:      SRCB_FOUR,
        resultsrc: RES_ALU,
        adrsrc:    1'b0,
        irwrite:   1'b1,
        regwrite:  1'b0,
        memwrite:  1'b0,
        retire:    1'b0
    };

    state_t state;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   ill_c;
    logic   pcw_c;

    // funct3 values the ALU datapath supports
    function automatic logic alu_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // funct3 -> ALU operation; sub_ok selects sub for R-type with funct7b5
    function automatic logic [ALU_W-1:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
        logic [ALU_W-1:0] a;
        case (f3)
            3'b000:  a = sub_ok ? ALU_SUB : ALU_ADD;
            3'b010:  a = ALU_SLT;
            3'b110:  a = ALU_OR;
            3'b111:  a = ALU_AND;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    // Control word for a given state; funct fields are stable in IR once decoded
    function automatic ctrl_t moore_ctrl(input state_t st, input logic [2:0] f3, input logic f7b5);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH:    c = CTRL_FETCH;
            S_DECODE: begin
                c.srca = SRCA_OLDPC;
                c.srcb = SRCB_IMM;
            end
            S_MEMADR: begin
                c.srca = SRCA_RD1;
                c.srcb = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.resultsrc = RES_ALUOUT;
                c.adrsrc    = 1'b1;
            end
            S_MEMWB: begin
                c.resultsrc = RES_DATA;
                c.regwrite  = 1'b1;
                c.retire    = 1'b1;
            end
            S_MEMWRITE: begin
                c.resultsrc = RES_ALUOUT;
                c.adrsrc    = 1'b1;
                c.memwrite  = 1'b1;
                c.retire    = 1'b1;
            end
            S_EXECR: begin
                c.srca    = SRCA_RD1;
                c.srcb    = SRCB_RD2;
                c.aluctrl = alu_decode(f3, f7b5);
            end
            S_EXECI: begin
                c.srca    = SRCA_RD1;
                c.srcb    = SRCB_IMM;
                c.aluctrl = alu_decode(f3, 1'b0);
            end
            S_ALUWB: begin
                c.resultsrc = RES_ALUOUT;
                c.regwrite  = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH: begin
                c.srca      = SRCA_RD1;
                c.srcb      = SRCB_RD2;
                c.aluctrl   = ALU_SUB;
                c.resultsrc = RES_ALUOUT;
                c.retire    = (f3[2:1] == 2'b00);
            end
            S_JAL: begin
                c.srca      = SRCA_OLDPC;
                c.srcb      = SRCB_FOUR;
                c.aluctrl   = ALU_ADD;
                c.resultsrc = RES_ALUOUT;
            end
            default:    c = CTRL_FETCH;
        endcase
        return c;
    endfunction

    // Next-state decode plus the input-dependent PCWrite and illegal terms
    always_comb begin
        state_d = S_FETCH;
        ill_c   = 1'b0;
        pcw_c   = 1'b0;
        case (state)
            S_FETCH: begin
                state_d = S_DECODE;
                pcw_c   = 1'b1;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d = S_FETCH;
                        ill_c   = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR, S_EXECI: begin
                if (alu_f3_ok(funct3)) begin
                    state_d = S_ALUWB;
                end else begin
                    state_d = S_FETCH;
                    ill_c   = 1'b1;
                end
            end
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH: begin
                state_d = S_FETCH;
                if (funct3[2:1] == 2'b00) begin
                    pcw_c = ZeroE ^ funct3[0];
                end else begin
                    ill_c = 1'b1;
                end
            end
            S_JAL: begin
                state_d = S_ALUWB;
                pcw_c   = 1'b1;
            end
            default:    state_d = S_FETCH;
        endcase
    end

    // State and registered control word; reset parks in FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_FETCH;
            ctrl_q <= CTRL_FETCH;
        end else begin
            state  <= state_d;
            ctrl_q <= moore_ctrl(state_d, funct3, funct7b5);
        end
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BR:   ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Selects come straight from the control word; enables and pulses are
    // suppressed while reset is held so an aborted instruction writes nothing
    assign ALUctrl   = ctrl_q.aluctrl;
    assign ALUSrcA   = ctrl_q.srca;
    assign ALUSrcB   = ctrl_q.srcb;
    assign ResultSrc = ctrl_q.resultsrc;
    assign AdrSrc    = ctrl_q.adrsrc;
    assign IRWrite   = ctrl_q.irwrite  & ~rst;
    assign RegWrite  = ctrl_q.regwrite & ~rst;
    assign MemWrite  = ctrl_q.memwrite & ~rst;
    assign retire    = ctrl_q.retire   & ~rst;
    assign PCWrite   = pcw_c & ~rst;
    assign illegal   = ill_c & ~rst;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: directed instruction table, reset
// corner cases and randomized instructions against a per-cycle timeline model.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       ZeroE;
    logic [2:0] ALUctrl;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal;

    int nvec  = 0;
    int nfail = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] SYS = 7'b1110011;

    typedef struct packed {
        logic [2:0] alu;
        logic [1:0] sa, sb, rs, imm;
        logic       adr, irw, pcw, rw, mw, ret, ill;
    } exp_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         lat;
        logic [2:0] alu2;
        logic       pcw2;
        int         rw, mw, ill;
    } vec_t;

    exp_t act;
    assign act = {ALUctrl, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                  AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal};

    control_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .ZeroE(ZeroE),
        .ALUctrl(ALUctrl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .retire(retire), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic bit op_known(input logic [6:0] o);
        return o == LW || o == SW || o == RT || o == IT || o == BR || o == JL;
    endfunction

    function automatic bit f3_alu_ok(input logic [2:0] f3);
        return f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7;
    endfunction

    // Cycle count of an instruction, FETCH included
    function automatic int model_len(input logic [6:0] o, input logic [2:0] f3);
        if (o == LW) return 5;
        if (o == SW || o == JL) return 4;
        if (o == RT || o == IT) return f3_alu_ok(f3) ? 4 : 3;
        if (o == BR) return 3;
        return 2;
    endfunction

    // Expected outputs in cycle k of an instruction
    function automatic exp_t model(input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z, input int k);
        exp_t e;
        e = '0;
        e.imm = (o == SW) ? 2'd1 : (o == BR) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        if (k == 0) begin
            e.sb = 2'd2; e.rs = 2'd2; e.irw = 1'b1; e.pcw = 1'b1;
        end else if (k == 1) begin
            e.sa = 2'd1; e.sb = 2'd1; e.ill = !op_known(o);
        end else if (o == LW || o == SW) begin
            if (k == 2) begin
                e.sa = 2'd2; e.sb = 2'd1;
            end else if (o == LW && k == 3) begin
                e.adr = 1'b1;
            end else if (o == LW) begin
                e.rs = 2'd1; e.rw = 1'b1; e.ret = 1'b1;
            end else begin
                e.adr = 1'b1; e.mw = 1'b1; e.ret = 1'b1;
            end
        end else if (o == RT || o == IT) begin
            if (k == 2) begin
                e.sa = 2'd2;
                e.sb = (o == RT) ? 2'd0 : 2'd1;
                case (f3)
                    3'd0:    e.alu = (o == RT && f7) ? 3'd1 : 3'd0;
                    3'd2:    e.alu = 3'd5;
                    3'd6:    e.alu = 3'd3;
                    3'd7:    e.alu = 3'd2;
                    default: e.alu = 3'd0;
                endcase
                e.ill = !f3_alu_ok(f3);
            end else begin
                e.rw = 1'b1; e.ret = 1'b1;
            end
        end else if (o == BR) begin
            e.sa = 2'd2; e.alu = 3'd1;
            if (f3 == 3'd0) begin
                e.pcw = z; e.ret = 1'b1;
            end else if (f3 == 3'd1) begin
                e.pcw = !z; e.ret = 1'b1;
            end else begin
                e.ill = 1'b1;
            end
        end else if (o == JL) begin
            if (k == 2) begin
                e.sa = 2'd1; e.sb = 2'd2; e.pcw = 1'b1;
            end else begin
                e.rw = 1'b1; e.ret = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic check18(input logic [17:0] a, input logic [17:0] e, input string name);
        nvec++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %b expected %b", name, a, e);
        end
    endtask

    // Drives one instruction starting in FETCH; returns at mid-cycle of the next FETCH
    // (or right after cycle stop_k is checked when stop_k >= 0)
    task automatic run_instr(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                             input logic iz, input int stop_k,
                             output int lat, output logic [2:0] alu2, output logic pcw2,
                             output int rw, output int mw, output int ill);
        int mlen;
        op = iop; funct3 = if3; funct7b5 = if7; ZeroE = iz;
        #1;
        mlen = model_len(iop, if3);
        lat = 99; alu2 = 3'd0; pcw2 = 1'b0; rw = 0; mw = 0; ill = 0;
        for (int k = 0; k < mlen; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            if (k > 0 && IRWrite && lat == 99) lat = k;
            check18(act, model(iop, if3, if7, iz, k),
                    $sformatf("op=%b f3=%b f7=%b z=%b cyc=%0d", iop, if3, if7, iz, k));
            if (k == 2) begin
                alu2 = ALUctrl; pcw2 = PCWrite;
            end
            rw += int'(RegWrite); mw += int'(MemWrite); ill += int'(illegal);
            if (k == stop_k) return;
        end
        @(negedge clk);
        #1;
        check18({17'b0, IRWrite}, 18'd1, $sformatf("refetch op=%b", iop));
        if (IRWrite && lat == 99) lat = mlen;
    endtask

    vec_t tbl[16];

    initial begin
        int lat, rw, mw, ill;
        logic [2:0] alu2;
        logic pcw2;
        logic [6:0] rop;

        //          op   f3    f7    z     lat alu2  pcw2  rw mw ill
        tbl[0]  = '{LW,  3'd2, 1'b0, 1'b0, 5, 3'd0, 1'b0, 1, 0, 0};
        tbl[1]  = '{SW,  3'd2, 1'b0, 1'b0, 4, 3'd0, 1'b0, 0, 1, 0};
        tbl[2]  = '{RT,  3'd0, 1'b1, 1'b0, 4, 3'd1, 1'b0, 1, 0, 0};
        tbl[3]  = '{RT,  3'd0, 1'b0, 1'b0, 4, 3'd0, 1'b0, 1, 0, 0};
        tbl[4]  = '{IT,  3'd0, 1'b1, 1'b0, 4, 3'd0, 1'b0, 1, 0, 0};
        tbl[5]  = '{RT,  3'd2, 1'b0, 1'b0, 4, 3'd5, 1'b0, 1, 0, 0};
        tbl[6]  = '{IT,  3'd6, 1'b0, 1'b0, 4, 3'd3, 1'b0, 1, 0, 0};
        tbl[7]  = '{RT,  3'd7, 1'b0, 1'b0, 4, 3'd2, 1'b0, 1, 0, 0};
        tbl[8]  = '{BR,  3'd1, 1'b0, 1'b0, 3, 3'd1, 1'b1, 0, 0, 0};
        tbl[9]  = '{BR,  3'd1, 1'b0, 1'b1, 3, 3'd1, 1'b0, 0, 0, 0};
        tbl[10] = '{BR,  3'd0, 1'b0, 1'b0, 3, 3'd1, 1'b0, 0, 0, 0};
        tbl[11] = '{BR,  3'd0, 1'b0, 1'b1, 3, 3'd1, 1'b1, 0, 0, 0};
        tbl[12] = '{SYS, 3'd0, 1'b0, 1'b0, 2, 3'd0, 1'b0, 0, 0, 1};
        tbl[13] = '{RT,  3'd1, 1'b0, 1'b0, 3, 3'd0, 1'b0, 0, 0, 1};
        tbl[14] = '{BR,  3'd4, 1'b0, 1'b1, 3, 3'd1, 1'b0, 0, 0, 1};
        tbl[15] = '{JL,  3'd0, 1'b0, 1'b0, 4, 3'd0, 1'b1, 1, 0, 0};

        rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; ZeroE = 1'b0;

        // Reset holds all enables and pulses low
        repeat (2) @(negedge clk);
        #1;
        check18({12'b0, IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal}, 18'd0, "reset enables");
        @(negedge clk);
        rst = 1'b0;

        // Directed instruction table
        for (int i = 0; i < 16; i++) begin
            run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, -1, lat, alu2, pcw2, rw, mw, ill);
            check18(18'(lat), 18'(tbl[i].lat), $sformatf("latency row %0d", i));
            check18(18'(alu2), 18'(tbl[i].alu2), $sformatf("alu row %0d", i));
            check18(18'(pcw2), 18'(tbl[i].pcw2), $sformatf("pcwrite row %0d", i));
            check18(18'(rw), 18'(tbl[i].rw), $sformatf("regwrite count row %0d", i));
            check18(18'(mw), 18'(tbl[i].mw), $sformatf("memwrite count row %0d", i));
            check18(18'(ill), 18'(tbl[i].ill), $sformatf("illegal count row %0d", i));
        end

        // Reset during MEMWRITE aborts the store at once
        run_instr(SW, 3'd2, 1'b0, 1'b0, 3, lat, alu2, pcw2, rw, mw, ill);
        check18(18'(mw), 18'd1, "memwrite before abort");
        #1 rst = 1'b1;
        #1;
        check18({12'b0, IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal}, 18'd0, "abort enables");
        @(negedge clk);
        #1;
        check18({12'b0, IRWrite, PCWrite, RegWrite, MemWrite, retire, illegal}, 18'd0, "held reset enables");
        @(negedge clk);
        rst = 1'b0;
        run_instr(LW, 3'd2, 1'b0, 1'b0, -1, lat, alu2, pcw2, rw, mw, ill);
        check18(18'(lat), 18'd5, "lw after reset latency");

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = IT;
                4: rop = BR;
                5: rop = JL;
                6: rop = SYS;
                default: rop = 7'($urandom);
            endcase
            run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), -1,
                      lat, alu2, pcw2, rw, mw, ill);
            check18(18'(lat), 18'(model_len(rop, funct3)), $sformatf("random latency %0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
